// File: rtl/codec_read_sequencer_if.sv
// Codec read bus and frame-result handshake between the sequencer and its neighbours.
// master: the sequencer side; slave: the codec/consumer side.
interface codec_read_sequencer_if #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
);
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;
    logic [DATA_W-1:0] frame_peak;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_loud;
    logic              frame_valid;
    logic              frame_ready;
    logic              overrun;

    modport master (
        input  read_ready, readdata_left, readdata_right, frame_ready,
        output read, frame_peak, frame_count, frame_loud, frame_valid, overrun
    );

    modport slave (
        output read_ready, readdata_left, readdata_right, frame_ready,
        input  read, frame_peak, frame_count, frame_loud, frame_valid, overrun
    );
endinterface

// File: rtl/codec_read_sequencer.sv
// Reads codec ADC samples one per 3 cycles, rectifies them and reports per-frame peak/count.
// Optional STEREO_MIX_EN: analyse the floor-averaged left+right mix instead of the right channel.
module codec_read_sequencer #(
    parameter int                DATA_W      = 24,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] LOUD_THRESH = 24'h040000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  frame_tick,
    codec_read_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_WAIT, S_READ, S_ACC} state_t;

    state_t state, state_next;
    logic   read_c;

    logic signed [DATA_W-1:0] raw_sample;
    logic signed [DATA_W-1:0] sample_p1;
    logic        [DATA_W-1:0] mag_p1;
    logic                     acc_update;

    logic [DATA_W-1:0] peak_acc;
    logic [CNT_W-1:0]  count_acc;
    logic [DATA_W-1:0] frame_peak_r;
    logic [CNT_W-1:0]  frame_count_r;
    logic              frame_loud_r;
    logic              frame_valid_r;
    logic              overrun_r;
    logic              slot_free;

    function automatic logic signed [DATA_W-1:0] mix_sample(
        input logic signed [DATA_W-1:0] l,
        input logic signed [DATA_W-1:0] r
    );
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] half;
        sum  = {l[DATA_W-1], l} + {r[DATA_W-1], r};
        half = sum >>> 1;
        return half[DATA_W-1:0];
    endfunction

    // The most negative input wraps to 2^(DATA_W-1), which is exactly its magnitude unsigned.
    function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] s);
        logic signed [DATA_W-1:0] neg;
        neg = -s;
        return s[DATA_W-1] ? $unsigned(neg) : $unsigned(s);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

`ifdef STEREO_MIX_EN
    assign raw_sample = mix_sample(bus.readdata_left, bus.readdata_right);
`else
    logic unused_left;
    assign unused_left = ^bus.readdata_left;
    assign raw_sample  = bus.readdata_right;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= S_WAIT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        read_c     = 1'b0;
        case (state)
            S_WAIT: if (enable && bus.read_ready) state_next = S_READ;
            S_READ: begin
                read_c     = 1'b1;
                state_next = S_ACC;
            end
            S_ACC:   state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    assign bus.read = read_c;

    // Stage p1: sample captured on the same edge that ends the read strobe.
    always_ff @(posedge CLOCK_50) begin
        if (state == S_READ) sample_p1 <= raw_sample;
    end

    assign mag_p1     = rectify(sample_p1);
    assign acc_update = (state == S_ACC);
    assign slot_free  = !frame_valid_r || bus.frame_ready;

    // Stage p2: accumulator update and frame close; a colliding sample opens the new frame.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            peak_acc      <= '0;
            count_acc     <= '0;
            frame_peak_r  <= '0;
            frame_count_r <= '0;
            frame_loud_r  <= 1'b0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (frame_tick) begin
            peak_acc  <= acc_update ? mag_p1 : '0;
            count_acc <= acc_update ? CNT_W'(1) : '0;
            if (slot_free) begin
                frame_peak_r  <= peak_acc;
                frame_count_r <= count_acc;
                frame_loud_r  <= (peak_acc >= LOUD_THRESH);
                frame_valid_r <= 1'b1;
            end else begin
                overrun_r <= 1'b1;
            end
        end else begin
            if (acc_update) begin
                peak_acc  <= (mag_p1 > peak_acc) ? mag_p1 : peak_acc;
                count_acc <= sat_inc(count_acc);
            end
            if (bus.frame_ready) frame_valid_r <= 1'b0;
        end
    end

    assign bus.frame_peak  = frame_peak_r;
    assign bus.frame_count = frame_count_r;
    assign bus.frame_loud  = frame_loud_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_codec_read_sequencer.sv
// Scoreboard bench for codec_read_sequencer: directed stimulus pushes expected frames, a monitor pops them.
module tb_codec_read_sequencer;
    localparam int DATA_W = 24;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] peak;
        logic [CNT_W-1:0]  count;
        logic              loud;
    } frame_t;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic enable     = 1'b0;
    logic frame_tick = 1'b0;

    int tests = 0;
    int fails = 0;
    frame_t exp_q[$];

    codec_read_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    codec_read_sequencer #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .LOUD_THRESH(24'h040000)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .frame_tick(frame_tick),
        .bus       (bus.master)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.read) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL read_timeout: got no read strobe, expected one within 10 cycles");
        end
    endtask

    // Returns once the sample has gone through S_READ and S_ACC.
    task automatic feed(input logic [DATA_W-1:0] right, input logic [DATA_W-1:0] left);
        bus.readdata_right = right;
        bus.readdata_left  = left;
        bus.read_ready     = 1'b1;
        wait_read();
        step();
        bus.read_ready = 1'b0;
        step();
    endtask

    task automatic feed1(input logic [DATA_W-1:0] s);
        feed(s, s);
    endtask

    task automatic tick(input bit push, input logic [DATA_W-1:0] peak,
                        input logic [CNT_W-1:0] count, input logic loud);
        if (push) exp_q.push_back('{peak: peak, count: count, loud: loud});
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        @(negedge clk);
        check("tick_to_valid", bus.frame_valid, 1);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.frame_valid && bus.frame_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got peak %0h count %0d, expected no frame",
                         bus.frame_peak, bus.frame_count);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_peak",  bus.frame_peak,  e.peak);
                check("frame_count", bus.frame_count, e.count);
                check("frame_loud",  bus.frame_loud,  e.loud);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] cadence;
        int         reads;

        bus.read_ready     = 1'b1;
        bus.readdata_right = '0;
        bus.readdata_left  = '0;
        bus.frame_ready    = 1'b1;
        enable             = 1'b1;
        reset_n            = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_read",    bus.read,        0);
        check("rst_valid",   bus.frame_valid, 0);
        check("rst_overrun", bus.overrun,     0);
        check("rst_peak",    bus.frame_peak,  0);
        check("rst_count",   bus.frame_count, 0);
        check("rst_loud",    bus.frame_loud,  0);

        // First strobe one cycle after release, then one every third cycle.
        reset_n = 1'b1;
        cadence = 6'b100100;
        for (int i = 5; i >= 0; i--) begin
            @(negedge clk);
            check($sformatf("cadence_%0d", 5 - i), bus.read, cadence[i]);
        end
        bus.read_ready = 1'b0;
        tick(1, 24'h000000, 16'd2, 1'b0);
        tick(1, 24'h000000, 16'd0, 1'b0);

        // Enable dropped during S_READ: the read completes, no new one starts.
        bus.readdata_right = 24'h000007;
        bus.readdata_left  = 24'h000007;
        bus.read_ready     = 1'b1;
        wait_read();
        enable = 1'b0;
        reads  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.read) reads++;
        end
        check("enable_gate", reads, 0);
        bus.read_ready = 1'b0;
        enable         = 1'b1;
        step();
        tick(1, 24'h000007, 16'd1, 1'b0);

        feed1(24'h000100);
        feed1(24'hFFF000);
        feed1(24'h000050);
        tick(1, 24'h001000, 16'd3, 1'b0);

        feed1(24'h800000);
        tick(1, 24'h800000, 16'd1, 1'b1);
        feed1(24'h03FFFF);
        tick(1, 24'h03FFFF, 16'd1, 1'b0);
        feed1(24'hFC0000);
        tick(1, 24'h040000, 16'd1, 1'b1);

        feed(24'hFFFFF0, 24'h000010);
`ifdef STEREO_MIX_EN
        tick(1, 24'h000000, 16'd1, 1'b0);
`else
        tick(1, 24'h000010, 16'd1, 1'b0);
`endif

        // Overrun: second frame dropped while the first is held.
        step();
        bus.frame_ready = 1'b0;
        feed1(24'h000300);
        tick(1, 24'h000300, 16'd1, 1'b0);
        check("overrun_before", bus.overrun, 0);
        feed1(24'h000500);
        tick(0, 24'h000000, 16'd0, 1'b0);
        check("held_peak",   bus.frame_peak,  24'h000300);
        check("held_count",  bus.frame_count, 1);
        check("overrun_set", bus.overrun,     1);
        step();
        bus.frame_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_drop",    bus.frame_valid, 0);
        check("overrun_stick", bus.overrun,     1);

        // Collision: tick lands in S_ACC, the sample opens the next frame.
        feed1(24'h000040);
        bus.readdata_right = 24'h000200;
        bus.readdata_left  = 24'h000200;
        bus.read_ready     = 1'b1;
        wait_read();
        step();
        bus.read_ready = 1'b0;
        exp_q.push_back('{peak: 24'h000040, count: 16'd1, loud: 1'b0});
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        @(negedge clk);
        check("collide_valid", bus.frame_valid, 1);
        tick(1, 24'h000200, 16'd1, 1'b0);

        step();
        step();
        step();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/codec_read_sequencer.md
Name: codec_read_sequencer

Overview:
Sequences reads from the audio codec ADC FIFO and turns the stream into per-frame peak statistics for the signal analyser. It watches read_ready and issues single-cycle read strobes, one per sample. It captures and rectifies each sample and tracks the peak magnitude and sample count over each 60 Hz frame. On every frame tick it hands the result downstream over a valid/ready handshake. It sits between audio_codec and Signal_Analyser and is clocked by CLOCK_50.

Parameters:
DATA_W, 24, codec sample width (signed two's complement)
CNT_W, 16, sample counter width
LOUD_THRESH, 24'h040000, peak magnitude at or above which the loud flag is set

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  permits new codec reads
read_ready  in  1  codec ADC FIFO holds a sample
readdata_left  in  DATA_W  codec left channel sample
readdata_right  in  DATA_W  codec right channel sample
read  out  1  one-cycle read strobe to the codec
frame_tick  in  1  one-cycle pulse from the 60 Hz counter
frame_peak  out  DATA_W  unsigned peak magnitude of the completed frame
frame_count  out  CNT_W  number of samples in the completed frame
frame_loud  out  1  frame_peak >= LOUD_THRESH
frame_valid  out  1  frame result held and valid
frame_ready  in  1  consumer accepts the frame result
overrun  out  1  sticky flag: a frame was dropped

Behaviour:
- Reset: one is synchronous on the CLOCK_50 edge while reset_n=0.
  - Every output is driven to 0.
  - The FSM returns to S_WAIT.
  - The accumulator peak and count are cleared.
- FSM:
  - S_WAIT: read=0. If enable && read_ready, go to S_READ.
  - S_READ: read=1 for exactly one cycle. The sample is registered on this same edge. Go to S_ACC.
  - S_ACC: read=0. Update the accumulator with the registered sample. Go to S_WAIT.
  - At most one read per 3 cycles. This guarantees read_ready has updated before it is sampled again.
- enable deasserted while in S_READ or S_ACC: the sequence in progress completes and no new read starts. Frame ticks are processed whatever the value of enable.
- Sample selection: readdata_right is used by default (see the optional feature).
- Rectification:
  - mag = |sample|, unsigned DATA_W bits.
  - The most negative input -2^(DATA_W-1) gives mag = 2^(DATA_W-1), e.g. 24'h800000. No overflow.
- Accumulator:
  - peak <= max(peak, mag).
  - count <= count + 1, saturating at all ones.
- Frame close (frame_tick=1):
  - The output slot is free when frame_valid=0, or when frame_valid=1 && frame_ready=1 in the same cycle.
  - Slot free: frame_peak, frame_count and frame_loud load the accumulator values and frame_valid=1 on the next cycle.
  - Slot busy: the frame is dropped, overrun is set to 1 and stays set until reset, and the held outputs are unchanged.
  - In both cases the accumulator is cleared.
- frame_tick in the same cycle as an S_ACC update:
  - The closing frame excludes that sample.
  - The new accumulator starts with peak=mag and count=1.
- Frame with zero samples: frame_peak=0, frame_count=0, frame_loud=0. It is still presented with frame_valid=1.
- Handshake:
  - frame_valid stays high until the cycle with frame_ready=1, then drops on the next cycle unless a new frame loads in that same cycle.
  - The held outputs are stable while frame_valid=1.
  - frame_ready has no effect while frame_valid=0.
- Latency:
  - read_ready to read strobe: 1 cycle.
  - Read to accumulator update: 2 cycles.
  - frame_tick to frame_valid: 1 cycle.

Optional Feature:
STEREO_MIX_EN:
- Defined: sample = (sext(left) + sext(right)) >>> 1, computed at DATA_W+1 bits, arithmetic shift with floor rounding, truncated to DATA_W. Rectification is then applied as above.
- Undefined: readdata_left is ignored and only readdata_right is used.

Test Plan:
- Reset: reset_n=0 for 2 cycles with read_ready=1 -> read=0, frame_valid=0, overrun=0, all outputs 0. After release, the first read pulse comes 1 cycle after read_ready is seen.
- Read cadence: read_ready held at 1 -> read pulses of one cycle each, every 3 cycles, with no back-to-back strobes.
- Peak and count: right channel samples 24'h000100, 24'hFFF000, 24'h000050, then frame_tick -> frame_peak=24'h001000, frame_count=3, frame_loud=0, frame_valid=1 one cycle after the tick.
- Extremes: sample 24'h800000 then tick -> frame_peak=24'h800000, frame_loud=1. With STEREO_MIX_EN, left 24'h000010 and right 24'hFFFFF0 -> sample=0, frame_peak=0.
- Overrun: frame_ready=0, two ticks -> the first frame is held unchanged and overrun=1. Then frame_ready=1 -> frame_valid drops the next cycle and overrun stays 1.
- Collision: frame_tick in the same cycle as S_ACC with mag 24'h000200 -> the closed frame excludes it. The next frame reports frame_count=1, frame_peak=24'h000200 when no further samples arrive.
